// File: rtl/tank_hit_sequencer.sv
// Hit/respawn sequencer for the two-tank game: per-tank burst, bot reset
// and invulnerability windows, plus scoring and winner detection.

module tank_fsm #(
  parameter logic [31:0] BURST_CYCLES = 32'd50331648,
  parameter logic [31:0] RESET_CYCLES = 32'd17,
  parameter logic [31:0] GUARD_CYCLES = 32'd25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic accept,
  input  logic restart,
  output logic alive,
  output logic burst,
  output logic bot_reset,
  output logic guard
);

  typedef enum logic [1:0] {
    ALIVE,
    BURST,
    RESPAWN,
    GUARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] count;
  logic [31:0] count_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ALIVE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // count holds the cycles left in the current window minus one
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      ALIVE: begin
        if (accept) begin
          state_next = BURST;
          count_next = BURST_CYCLES - 32'd1;
        end
      end
      BURST: begin
        if (count == '0) begin
          state_next = RESPAWN;
          count_next = RESET_CYCLES - 32'd1;
        end else begin
          count_next = count - 32'd1;
        end
      end
      RESPAWN: begin
        if (count == '0) begin
          state_next = GUARD;
          count_next = GUARD_CYCLES - 32'd1;
        end else begin
          count_next = count - 32'd1;
        end
      end
      GUARD: begin
        if (count == '0) begin
          state_next = ALIVE;
          count_next = '0;
        end else begin
          count_next = count - 32'd1;
        end
      end
      default: begin
        state_next = ALIVE;
        count_next = '0;
      end
    endcase
    if (restart) begin
      state_next = RESPAWN;
      count_next = RESET_CYCLES - 32'd1;
    end
  end

  assign alive     = (state == ALIVE);
  assign burst     = (state == BURST);
  assign bot_reset = (state == RESPAWN);
  assign guard     = (state == GUARD);

endmodule

module tank_hit_sequencer #(
  parameter logic [31:0] BURST_CYCLES = 32'd50331648,
  parameter logic [31:0] RESET_CYCLES = 32'd17,
  parameter logic [31:0] GUARD_CYCLES = 32'd25000000,
  parameter logic [3:0]  WIN_SCORE    = 4'd5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hit_red,
  input  logic       hit_blue,
  input  logic       start,
  output logic       burst_red,
  output logic       burst_blue,
  output logic       bot_reset_red,
  output logic       bot_reset_blue,
  output logic       guard_red,
  output logic       guard_blue,
  output logic [3:0] score_red,
  output logic [3:0] score_blue,
  output logic       game_over,
  output logic [1:0] winner
);

  logic       alive_red;
  logic       alive_blue;
  logic       accept_red;
  logic       accept_blue;
  logic       restart;
  logic [3:0] red_next;
  logic [3:0] blue_next;
  logic       win_red;
  logic       win_blue;

  always_comb begin
    accept_red  = hit_red & alive_red & ~game_over;
    accept_blue = hit_blue & alive_blue & ~game_over;
    restart     = start & game_over;
    // a hit on one tank scores for the other
    red_next    = score_red + {3'b000, accept_blue};
    blue_next   = score_blue + {3'b000, accept_red};
    win_red     = (red_next == WIN_SCORE);
    win_blue    = (blue_next == WIN_SCORE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      score_red  <= '0;
      score_blue <= '0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else if (restart) begin
      score_red  <= '0;
      score_blue <= '0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else if (!game_over) begin
      score_red  <= red_next;
      score_blue <= blue_next;
      if (win_red | win_blue) begin
        game_over <= 1'b1;
        winner    <= {win_blue, win_red};
      end
    end
  end

  tank_fsm #(
    .BURST_CYCLES(BURST_CYCLES),
    .RESET_CYCLES(RESET_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_red (
    .clock    (clock),
    .reset    (reset),
    .accept   (accept_red),
    .restart  (restart),
    .alive    (alive_red),
    .burst    (burst_red),
    .bot_reset(bot_reset_red),
    .guard    (guard_red)
  );

  tank_fsm #(
    .BURST_CYCLES(BURST_CYCLES),
    .RESET_CYCLES(RESET_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_blue (
    .clock    (clock),
    .reset    (reset),
    .accept   (accept_blue),
    .restart  (restart),
    .alive    (alive_blue),
    .burst    (burst_blue),
    .bot_reset(bot_reset_blue),
    .guard    (guard_blue)
  );

endmodule

// File: tb/tb_tank_hit_sequencer.sv
// Bench for tank_hit_sequencer: directed scenarios plus random traffic
// checked against a cycle-count model of each tank's hit sequence.

module tb_tank_hit_sequencer;

  localparam int B = 8;
  localparam int R = 2;
  localparam int G = 4;
  localparam int W = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hit_red = 1'b0;
  logic       hit_blue = 1'b0;
  logic       start = 1'b0;
  logic       burst_red;
  logic       burst_blue;
  logic       bot_reset_red;
  logic       bot_reset_blue;
  logic       guard_red;
  logic       guard_blue;
  logic [3:0] score_red;
  logic [3:0] score_blue;
  logic       game_over;
  logic [1:0] winner;

  tank_hit_sequencer #(
    .BURST_CYCLES(32'd8),
    .RESET_CYCLES(32'd2),
    .GUARD_CYCLES(32'd4),
    .WIN_SCORE   (4'd3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hit_red       (hit_red),
    .hit_blue      (hit_blue),
    .start         (start),
    .burst_red     (burst_red),
    .burst_blue    (burst_blue),
    .bot_reset_red (bot_reset_red),
    .bot_reset_blue(bot_reset_blue),
    .guard_red     (guard_red),
    .guard_blue    (guard_blue),
    .score_red     (score_red),
    .score_blue    (score_blue),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clock = ~clock;

  // model: t = cycles into a tank's hit sequence, 0 when alive
  int         t_r;
  int         t_b;
  int         m_sr;
  int         m_sb;
  bit         m_go;
  logic [1:0] m_win;
  int         n_cmp;
  int         n_err;

  logic [16:0] obs;
  assign obs = {burst_red, burst_blue, bot_reset_red, bot_reset_blue,
                guard_red, guard_blue, score_red, score_blue,
                game_over, winner};

  function automatic logic [2:0] phase(input int t);
    phase = {t >= 1 && t <= B,
             t > B && t <= B + R,
             t > B + R && t <= B + R + G};
  endfunction

  function automatic logic [16:0] expv();
    logic [2:0] pr;
    logic [2:0] pb;
    logic [3:0] sr;
    logic [3:0] sb;
    pr = phase(t_r);
    pb = phase(t_b);
    sr = 4'(m_sr);
    sb = 4'(m_sb);
    expv = {pr[2], pb[2], pr[1], pb[1], pr[0], pb[0],
            sr, sb, m_go, m_win};
  endfunction

  function automatic int adv(input int t);
    if (t == 0) adv = 0;
    else if (t + 1 > B + R + G) adv = 0;
    else adv = t + 1;
  endfunction

  task automatic cyc(input logic hr, input logic hb,
                     input logic st, input logic rn);
    bit acc_r;
    bit acc_b;
    hit_red  = hr;
    hit_blue = hb;
    start    = st;
    reset    = rn;
    @(posedge clock);
    if (!rn) begin
      t_r = 0; t_b = 0; m_sr = 0; m_sb = 0;
      m_go = 0; m_win = 2'b00;
    end else if (st && m_go) begin
      t_r = B + 1; t_b = B + 1; m_sr = 0; m_sb = 0;
      m_go = 0; m_win = 2'b00;
    end else begin
      acc_r = hr && t_r == 0 && !m_go;
      acc_b = hb && t_b == 0 && !m_go;
      t_r = adv(t_r);
      t_b = adv(t_b);
      if (acc_r) begin t_r = 1; m_sb++; end
      if (acc_b) begin t_b = 1; m_sr++; end
      if (!m_go && (m_sr == W || m_sb == W)) begin
        m_go  = 1;
        m_win = {m_sb == W, m_sr == W};
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0);
      n_cmp++;
      if (obs !== 17'd0) begin
        n_err++;
        $display("FAIL reset_hold got=%h want=0", obs);
      end
    end
    cyc(0, 0, 0, 1);
    n_cmp++;
    if (obs !== expv() || obs !== 17'd0) begin
      n_err++;
      $display("FAIL reset_release got=%h want=0", obs);
    end
  endtask

  task automatic test_single_hit();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    n_cmp++;
    if (score_blue !== 4'd1 || burst_red !== 1'b1 || burst_blue !== 1'b0) begin
      n_err++;
      $display("FAIL single_first got=%h want=%h", obs, expv());
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1);
      n_cmp++;
      if (obs !== expv()) begin
        n_err++;
        $display("FAIL single_seq[%0d] got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_ignored_hits();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 1);
      n_cmp++;
      if (obs !== expv()) begin
        n_err++;
        $display("FAIL held_hit[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    n_cmp++;
    if (score_blue !== 4'd2) begin
      n_err++;
      $display("FAIL held_score got=%0d want=2", score_blue);
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 1);
      n_cmp++;
      if (obs !== expv()) begin
        n_err++;
        $display("FAIL simul_hit[%0d] got=%h want=%h", k, obs, expv());
      end
      for (int i = 0; i < 15; i++) begin
        cyc(0, 0, 0, 1);
        n_cmp++;
        if (obs !== expv()) begin
          n_err++;
          $display("FAIL simul_seq[%0d] got=%h want=%h", k, obs, expv());
        end
      end
    end
    n_cmp++;
    if ({score_red, score_blue, game_over, winner} !== 11'b0011_0011_1_11) begin
      n_err++;
      $display("FAIL simul_final got=%h want=33/1/3",
               {score_red, score_blue, game_over, winner});
    end
  endtask

  task automatic test_restart();
    cyc(0, 0, 1, 1);
    n_cmp++;
    if ({bot_reset_red, bot_reset_blue, score_red, score_blue,
         game_over, winner} !== 13'b11_0000_0000_0_00) begin
      n_err++;
      $display("FAIL restart_first got=%h want=%h", obs, expv());
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, i == 3, 1);
      n_cmp++;
      if (obs !== expv()) begin
        n_err++;
        $display("FAIL restart_seq[%0d] got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    n_cmp++;
    if (burst_blue !== 1'b1) begin
      n_err++;
      $display("FAIL mid_burst got=%b want=1", burst_blue);
    end
    cyc(1, 1, 1, 0);
    n_cmp++;
    if (obs !== 17'd0) begin
      n_err++;
      $display("FAIL mid_reset got=%h want=0", obs);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    n_cmp++;
    if (obs !== expv() || score_red !== 4'd1 || burst_blue !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rehit got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_random();
    logic hr;
    logic hb;
    logic st;
    logic rn;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      hr = ($urandom_range(0, 2) == 0);
      hb = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 149) != 0);
      cyc(hr, hb, st, rn);
      n_cmp++;
      if (obs !== expv()) begin
        n_err++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    t_r = 0; t_b = 0; m_sr = 0; m_sb = 0;
    m_go = 0; m_win = 2'b00;
    test_reset();
    test_single_hit();
    test_ignored_hits();
    test_simultaneous();
    test_restart();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tank_hit_sequencer.md
# tank_hit_sequencer

Central hit/respawn controller for the two-tank game. It takes the hit pulses from the collision logic and sequences each tank through burst display, rojobot reset and a post-respawn invulnerability window. It also keeps score and declares the winner. Its `burst_*` outputs drive the icon blocks' burst/tank ROM selection, and its `bot_reset_*` outputs drive the rojobot reset lines. This replaces the per-icon burst timers with a single point of control.

## Interface
- BURST_CYCLES, 50331648: cycles a tank shows the burst icon after a hit.
- RESET_CYCLES, 17: cycles the rojobot reset pulse is held.
- GUARD_CYCLES, 25000000: post-respawn cycles during which hits on that tank are ignored.
- WIN_SCORE, 5: score that ends the game; legal range 1..15.
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low.
- hit_red  input  1  red tank struck this cycle; level, sampled every cycle.
- hit_blue  input  1  blue tank struck this cycle.
- start  input  1  new-game request; honoured only while game_over=1.
- burst_red  output  1  red tank shows the burst icon.
- burst_blue  output  1  blue tank shows the burst icon.
- bot_reset_red  output  1  active-high reset to the red rojobot.
- bot_reset_blue  output  1  active-high reset to the blue rojobot.
- guard_red  output  1  red tank is invulnerable; display may blink the icon.
- guard_blue  output  1  blue tank is invulnerable.
- score_red  output  4  hits scored by red, meaning hits on blue.
- score_blue  output  4  hits scored by blue.
- game_over  output  1  a tank reached WIN_SCORE.
- winner  output  2  01 red, 10 blue, 11 draw, 00 none.

## Operation
- There are two identical per-tank FSMs, each with its own 32-bit down-counter.
- States and exits:
  - ALIVE: exits when its hit=1 and game_over=0.
  - BURST: lasts BURST_CYCLES.
  - RESPAWN: lasts RESET_CYCLES.
  - GUARD: lasts GUARD_CYCLES, then returns to ALIVE.
- Outputs are a registered decode of state: burst=BURST, bot_reset=RESPAWN, guard=GUARD.
- A hit is accepted only in ALIVE with game_over=0. Hits in any other state, or while game_over=1, are dropped with no effect and are not queued.
- An accepted hit on blue increments score_red; an accepted hit on red increments score_blue.
- Simultaneous accepted hits on both tanks:
  - Both scores increment and both FSMs enter BURST together.
  - If both scores reach WIN_SCORE in the same cycle, winner=11.
- game_over and winner are set in the same cycle as the score that reaches WIN_SCORE. Both hold until reset or an accepted start.
- After game_over, sequences already in progress run to completion; no new hits are accepted.
- Scores never exceed WIN_SCORE.
- Accepted start (start=1 and game_over=1):
  - Scores, game_over and winner clear.
  - Both FSMs load RESPAWN with a fresh counter, so both bots return home, then go through GUARD.
- start while game_over=0 is ignored.
- start and reset are the only ways to clear the scores.

## Timing
- Reset value of every output is 0; both FSMs go to ALIVE and both counters to 0.
- Hit latency: hit sampled high at edge N while ALIVE gives burst=1 and the updated score from N+1.
- Window lengths are exact: burst high for exactly BURST_CYCLES clocks, bot_reset for exactly RESET_CYCLES, guard for exactly GUARD_CYCLES.
- There are no gap cycles between windows. The last burst cycle is immediately followed by the first bot_reset cycle, and likewise into guard.
- A held hit level does not retrigger until the FSM is back in ALIVE. If hit is still 1 on the first ALIVE cycle, it is accepted.
- Accepted start at edge N gives scores 0, game_over 0 and both bot_reset=1 from N+1.
- Reset asserted mid-sequence takes effect at the next edge and overrides hit and start. There is no residual pulse.
- Counter arithmetic is unsigned 32-bit; parameters are ≥1.

## Test plan
Use BURST_CYCLES=8, RESET_CYCLES=2, GUARD_CYCLES=4, WIN_SCORE=3.

- **Reset:** reset=0 for 3 cycles, then release → all outputs 0, score_red=score_blue=0.
- **Single hit:** one-cycle hit_red at edge N →
  - burst_red high N+1..N+8, bot_reset_red high N+9..N+10, guard_red high N+11..N+14, ALIVE at N+15;
  - score_blue=1 at N+1; blue outputs unchanged.
- **Ignored hits:** hit_red held high for 20 cycles → exactly one accepted hit (score_blue=1); a second hit is accepted at N+15 (score_blue=2).
- **Simultaneous hits:** hit_red and hit_blue together, three times, each after both FSMs return to ALIVE → scores 3/3, game_over=1 and winner=11 on the third accept; later hits change nothing.
- **Restart:** start=1 with game_over=1 → next cycle scores 0, game_over 0, winner 0, bot_reset_red=bot_reset_blue=1 for 2 cycles then guard for 4. start with game_over=0 → no change.
- **Reset mid-burst:** reset asserted at cycle 4 of burst_blue → all outputs 0 next edge; a hit_blue one cycle after release is accepted with score_red=1.
